// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N:1 word multiplexer behind a two-entry valid/ready output stage.
// The main register drives MuxOut and the skid register catches one extra word
// so the upstream can keep streaming while the downstream stalls for a cycle.
// SelErr latches any accepted out-of-range select until ErrClr.
module mux_n_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_IN*WORD_SIZE-1:0] MuxIn,
  input  logic [SEL_WIDTH-1:0]        Sel,
  input  logic                        InValid,
  output logic                        InReady,
  output logic [WORD_SIZE-1:0]        MuxOut,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic                        SelErr,
  input  logic                        ErrClr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] main_q, main_d;
  logic [WORD_SIZE-1:0] skid_q, skid_d;
  logic                 err_q, err_d;

  logic [WORD_SIZE-1:0] words [NUM_IN];
  logic [WORD_SIZE-1:0] sel_word;
  logic                 sel_hit;
  logic                 accept;
  logic                 consume;

  // Unpack the flat input bus into an indexable word array.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_word
    assign words[gi] = MuxIn[gi*WORD_SIZE +: WORD_SIZE];
  end

  // Select the addressed word; an unmatched select yields zero and flags an error.
  always_comb begin
    sel_word = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (Sel == SEL_WIDTH'(i)) begin
        sel_word = words[i];
        sel_hit  = 1'b1;
      end
    end
  end

  // Handshake strobes; readiness comes from the state register alone.
  assign accept  = InValid && (state_q != ST_FULL);
  assign consume = OutReady && (state_q != ST_EMPTY);

  // Next-state, storage and sticky-error update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    err_d   = err_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = sel_word;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = sel_word;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_d  = sel_word;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Setting wins over clearing so a simultaneous bad select is never lost.
    if (accept && !sel_hit) begin
      err_d = 1'b1;
    end else if (ErrClr) begin
      err_d = 1'b0;
    end
  end

  // State and data registers; reset discards any held words.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

  assign InReady  = (state_q != ST_FULL);
  assign OutValid = (state_q != ST_EMPTY);
  assign MuxOut   = main_q;
  assign SelErr   = err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Testbench for mux_n_pipe: directed vector table on a 4-input instance,
// illegal-select sequence on a 3-input instance, asynchronous reset in FULL,
// and a randomized run on a 16-input byte-wide instance against a queue model.
module tb_mux_n_pipe;

  logic Clk;
  logic Reset_n;

  int checks;
  int errors;

  // Instance A: 32-bit words, 4 inputs
  logic [127:0] a_mux_in;
  logic [1:0]   a_sel;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err, a_err_clr;
  logic [31:0]  a_mux_out;

  // Instance B: 32-bit words, 3 inputs, select can go out of range
  logic [95:0]  b_mux_in;
  logic [1:0]   b_sel;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err, b_err_clr;
  logic [31:0]  b_mux_out;

  // Instance C: 8-bit words, 16 inputs
  logic [127:0] c_mux_in;
  logic [3:0]   c_sel;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sel_err, c_err_clr;
  logic [7:0]   c_mux_out;

  mux_n_pipe #(.WORD_SIZE(32), .NUM_IN(4), .SEL_WIDTH(2)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .MuxIn(a_mux_in), .Sel(a_sel),
    .InValid(a_in_valid), .InReady(a_in_ready), .MuxOut(a_mux_out),
    .OutValid(a_out_valid), .OutReady(a_out_ready), .SelErr(a_sel_err),
    .ErrClr(a_err_clr)
  );

  mux_n_pipe #(.WORD_SIZE(32), .NUM_IN(3), .SEL_WIDTH(2)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .MuxIn(b_mux_in), .Sel(b_sel),
    .InValid(b_in_valid), .InReady(b_in_ready), .MuxOut(b_mux_out),
    .OutValid(b_out_valid), .OutReady(b_out_ready), .SelErr(b_sel_err),
    .ErrClr(b_err_clr)
  );

  mux_n_pipe #(.WORD_SIZE(8), .NUM_IN(16), .SEL_WIDTH(4)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .MuxIn(c_mux_in), .Sel(c_sel),
    .InValid(c_in_valid), .InReady(c_in_ready), .MuxOut(c_mux_out),
    .OutValid(c_out_valid), .OutReady(c_out_ready), .SelErr(c_sel_err),
    .ErrClr(c_err_clr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] exp_mux;
    logic        exp_valid;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Random-run model state
  logic [7:0] model_q [$];
  int         accepted;
  int         consumed;
  int         cycles;
  logic [7:0] prev_mux;
  logic       prev_stall;
  logic       acc;
  logic       con;
  logic [7:0] exp_word;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'hA0000000, 1'b1, 1'b1};
    vecs[1]  = '{2'd1, 1'b1, 1'b1, 32'hB1111111, 1'b1, 1'b1};
    vecs[2]  = '{2'd2, 1'b1, 1'b1, 32'hC2222222, 1'b1, 1'b1};
    vecs[3]  = '{2'd3, 1'b1, 1'b1, 32'hD3333333, 1'b1, 1'b1};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 32'hD3333333, 1'b0, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 1'b0, 32'hB1111111, 1'b1, 1'b1};
    vecs[6]  = '{2'd2, 1'b1, 1'b0, 32'hB1111111, 1'b1, 1'b0};
    vecs[7]  = '{2'd0, 1'b1, 1'b0, 32'hB1111111, 1'b1, 1'b0};
    vecs[8]  = '{2'd3, 1'b1, 1'b0, 32'hB1111111, 1'b1, 1'b0};
    vecs[9]  = '{2'd0, 1'b1, 1'b0, 32'hB1111111, 1'b1, 1'b0};
    vecs[10] = '{2'd0, 1'b0, 1'b1, 32'hC2222222, 1'b1, 1'b1};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 32'hC2222222, 1'b0, 1'b1};

    Reset_n     = 1'b0;
    a_mux_in    = 128'hD3333333_C2222222_B1111111_A0000000;
    a_sel       = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_err_clr = 1'b0;
    b_mux_in    = 96'hC2222222_B1111111_A0000000;
    b_sel       = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_err_clr = 1'b0;
    c_mux_in    = '0;
    c_sel       = '0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_err_clr = 1'b0;

    // Reset state
    step(); step();
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_ready", 64'(a_in_ready), 64'd1);
    check("rst_a_mux",   64'(a_mux_out), 64'd0);
    check("rst_a_err",   64'(a_sel_err), 64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    check("rst_c_valid", 64'(c_out_valid), 64'd0);
    Reset_n = 1'b1;
    step();
    check("post_rst_a_valid", 64'(a_out_valid), 64'd0);
    check("post_rst_a_ready", 64'(a_in_ready), 64'd1);

    // Streaming and back-pressure table on instance A
    for (int i = 0; i < 12; i++) begin
      a_sel       = vecs[i].sel;
      a_in_valid  = vecs[i].in_valid;
      a_out_ready = vecs[i].out_ready;
      step();
      $display("vec %0d sel=%0d iv=%0b or=%0b -> mux=%h ov=%0b ir=%0b",
               i, vecs[i].sel, vecs[i].in_valid, vecs[i].out_ready,
               a_mux_out, a_out_valid, a_in_ready);
      check($sformatf("vec%0d_mux", i),   64'(a_mux_out),   64'(vecs[i].exp_mux));
      check($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ready", i), 64'(a_in_ready),  64'(vecs[i].exp_ready));
    end
    a_in_valid = 1'b0;

    // Illegal select on 3-input instance B
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_sel       = 2'd3;
    step();
    $display("illegal sel=3 -> mux=%h err=%0b", b_mux_out, b_sel_err);
    check("ill_mux",   64'(b_mux_out),   64'd0);
    check("ill_valid", 64'(b_out_valid), 64'd1);
    check("ill_err",   64'(b_sel_err),   64'd1);
    b_sel = 2'd1;
    step();
    $display("legal sel=1 -> mux=%h err=%0b", b_mux_out, b_sel_err);
    check("legal1_mux", 64'(b_mux_out), 64'hB1111111);
    check("legal1_err", 64'(b_sel_err), 64'd1);
    b_in_valid = 1'b0;
    step();
    check("idle_err", 64'(b_sel_err), 64'd1);
    b_in_valid = 1'b1;
    b_sel      = 2'd3;
    b_err_clr  = 1'b1;
    step();
    $display("clr+sel=3 -> mux=%h err=%0b", b_mux_out, b_sel_err);
    check("clr_set_err", 64'(b_sel_err), 64'd1);
    check("clr_set_mux", 64'(b_mux_out), 64'd0);
    b_in_valid = 1'b0;
    step();
    $display("clr -> err=%0b", b_sel_err);
    check("clr_err", 64'(b_sel_err), 64'd0);
    b_err_clr  = 1'b0;
    b_in_valid = 1'b1;
    b_sel      = 2'd2;
    step();
    check("legal2_mux", 64'(b_mux_out), 64'hC2222222);
    check("legal2_err", 64'(b_sel_err), 64'd0);
    b_in_valid = 1'b0;
    step();

    // Asynchronous reset while instance A is FULL
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_sel       = 2'd1;
    step();
    a_sel = 2'd2;
    step();
    a_in_valid = 1'b0;
    check("pre_rst_full_ready", 64'(a_in_ready), 64'd0);
    #3;
    Reset_n = 1'b0;
    #1;
    $display("async reset -> mux=%h ov=%0b ir=%0b", a_mux_out, a_out_valid, a_in_ready);
    check("arst_valid", 64'(a_out_valid), 64'd0);
    check("arst_mux",   64'(a_mux_out),   64'd0);
    check("arst_ready", 64'(a_in_ready),  64'd1);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_sel       = 2'd3;
    step();
    check("arst_hold_valid", 64'(a_out_valid), 64'd0);
    Reset_n    = 1'b1;
    a_sel      = 2'd2;
    step();
    $display("after release sel=2 -> mux=%h ov=%0b", a_mux_out, a_out_valid);
    check("arst_lat_mux",   64'(a_mux_out),   64'hC2222222);
    check("arst_lat_valid", 64'(a_out_valid), 64'd1);
    a_in_valid = 1'b0;
    step();
    check("arst_drain_valid", 64'(a_out_valid), 64'd0);

    // Randomized run on instance C against a queue model
    accepted   = 0;
    consumed   = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_mux   = '0;
    while (accepted < 1000 && cycles < 20000) begin
      check("rnd_valid", 64'(c_out_valid), 64'(model_q.size() != 0));
      check("rnd_ready", 64'(c_in_ready),  64'(model_q.size() < 2));
      if (model_q.size() != 0) begin
        check("rnd_data", 64'(c_mux_out), 64'(model_q[0]));
      end
      if (prev_stall) begin
        check("rnd_stable", 64'(c_mux_out), 64'(prev_mux));
      end
      check("rnd_err", 64'(c_sel_err), 64'd0);

      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      c_sel       = 4'($urandom_range(0, 15));
      c_mux_in    = {$urandom, $urandom, $urandom, $urandom};
      exp_word    = 8'(c_mux_in >> (int'(c_sel) * 8));
      acc         = c_in_valid && (model_q.size() < 2);
      con         = c_out_ready && (model_q.size() != 0);
      prev_stall  = (model_q.size() != 0) && !c_out_ready;
      prev_mux    = c_mux_out;
      step();
      cycles++;
      if (con) begin
        $display("rnd consume %0d word=%h", consumed, model_q[0]);
        void'(model_q.pop_front());
        consumed++;
      end
      if (acc) begin
        $display("rnd accept %0d sel=%0d word=%h", accepted, c_sel, exp_word);
        model_q.push_back(exp_word);
        accepted++;
      end
    end
    check("rnd_budget", 64'(accepted), 64'd1000);
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (model_q.size() != 0) begin
        check("drain_data", 64'(c_mux_out), 64'(model_q[0]));
        void'(model_q.pop_front());
        consumed++;
      end
      step();
    end
    check("drain_valid", 64'(c_out_valid), 64'd0);
    check("drain_count", 64'(consumed), 64'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N:1 word multiplexer with a registered, flow-controlled output stage for the multicycle datapath. It selects one of NUM_IN packed input words per accepted transfer and presents it one cycle later behind a valid/ready handshake. A two-entry skid buffer sustains one transfer per cycle under back-pressure. A sticky error flag reports out-of-range selects.

## Interface
- WORD_SIZE, 32, width of each data word
- NUM_IN, 4, number of input words (2..16)
- SEL_WIDTH, 2, select width; must satisfy 2^SEL_WIDTH >= NUM_IN
- Clk  input  1  rising-edge clock; the only clock
- Reset_n  input  1  asynchronous active-low reset; deasserted synchronously to Clk
- MuxIn  input  NUM_IN*WORD_SIZE  packed inputs; word i = MuxIn[i*WORD_SIZE +: WORD_SIZE]
- Sel  input  SEL_WIDTH  index of the word to forward; sampled with InValid
- InValid  input  1  upstream offers {MuxIn, Sel}
- InReady  output  1  block can accept this cycle
- MuxOut  output  WORD_SIZE  selected word, registered
- OutValid  output  1  MuxOut holds a valid word
- OutReady  input  1  downstream consumes MuxOut
- SelErr  output  1  sticky: some accepted Sel was >= NUM_IN
- ErrClr  input  1  synchronous clear of SelErr

## Operation
- Accept: InValid && InReady at a rising edge. Consume: OutValid && OutReady at a rising edge.
- Selected word is MuxIn word Sel. If Sel >= NUM_IN, the word is all zeros, it is still transferred, and SelErr sets.
- Storage: main register (drives MuxOut) and skid register. State: EMPTY, ONE, FULL.
- InReady = (state != FULL), combinational from state only; never depends on InValid or OutReady.
- OutValid = (state != EMPTY).
- EMPTY: accept -> main <= word, ONE.
- ONE: accept and consume -> main <= word, stay ONE. Consume only -> EMPTY. Accept only -> skid <= word, FULL. Neither -> hold.
- FULL: consume -> main <= skid, ONE. No consume -> hold. No accept is possible in FULL.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- While OutValid && !OutReady, MuxOut is stable.
- In EMPTY, MuxOut holds its last value. It is not required to be zero.
- SelErr: set on any accept with Sel >= NUM_IN; cleared by ErrClr. Set and clear in the same cycle -> SelErr = 1.
- Sel, MuxIn and InValid are ignored when InReady = 0.

## Timing
- Reset values (asynchronous, immediate on Reset_n low):
  - state EMPTY
  - MuxOut 0, skid 0
  - OutValid 0, SelErr 0
  - InReady 1
- Reset asserted mid-transfer discards all held words. No handshake completes on an edge where Reset_n is low.
- Latency: a word accepted at edge k appears on MuxOut with OutValid = 1 after edge k (cycle k+1), when the stage was EMPTY, or ONE and consumed at k.
- Throughput: 1 word/cycle with OutReady held high. InReady never drops in that case.
- Back-pressure: the first stall cycle fills the skid and InReady falls after that edge. InReady rises the cycle after the first consume from FULL.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- Reset then stream with OutReady = 1:
  - stimulus: NUM_IN = 4; inputs A0000000, B1111111, C2222222, D3333333; Sel = 0,1,2,3 on consecutive cycles
  - response: MuxOut = A0000000, B1111111, C2222222, D3333333 one cycle after each accept; OutValid continuous; InReady always 1
- Back-pressure:
  - stimulus: accept Sel = 1 and Sel = 2 back to back with OutReady = 0; hold 3 cycles; then OutReady = 1
  - response: InReady = 0 after the second accept; MuxOut = word1 stable during the stall; then word2 next; InReady returns to 1
- Illegal select:
  - stimulus: NUM_IN = 3, SEL_WIDTH = 2, accept Sel = 3
  - response: MuxOut = 0, SelErr = 1 and remaining 1 through later legal transfers until ErrClr
  - stimulus: ErrClr together with another Sel = 3 accept
  - response: SelErr remains 1
- Asynchronous reset in FULL:
  - stimulus: pull Reset_n low mid-cycle
  - response: OutValid = 0, MuxOut = 0, InReady = 1 immediately; after release, the first accepted word emerges with normal latency
- Random valid/ready:
  - stimulus: 1000 random transfers, WORD_SIZE = 8, NUM_IN = 16
  - response: scoreboard order and data match exactly; no loss or duplication; MuxOut stable whenever stalled
